// File: rtl/matmul_driver_if.sv
// Operand/result stream handshake bundle for matmul_driver.
// The driver is the slave side; the feeding/consuming logic is the master.
interface matmul_driver_if #(
    parameter int S = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [S-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [S-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/matmul_driver.sv
// Streams A and B into a matmul engine, fires it, waits for completion
// and streams the product back out element by element.
module matmul_driver #(
    parameter int S       = 32,
    parameter int H       = 2,
    parameter int C       = 2,
    parameter int W       = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    matmul_driver_if.slave   bus,
    output logic             mm_start,
    output logic [H*C*S-1:0] mm_a,
    output logic [C*W*S-1:0] mm_b,
    input  logic [H*W*S-1:0] mm_o,
    input  logic             mm_done,
    output logic             busy,
    output logic             err
);

    localparam int NA = H * C;
    localparam int NB = C * W;
    localparam int NO = H * W;
    localparam int M1 = (NA > NB) ? NA : NB;
    localparam int M2 = (M1 > NO) ? M1 : NO;
    localparam int MX = (M2 > TIMEOUT) ? M2 : TIMEOUT;
    localparam int CW = $clog2(MX + 1);

    typedef enum logic [2:0] {
        ST_LOAD_A,
        ST_LOAD_B,
        ST_FIRE,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [H*C*S-1:0]   a_q, a_d;
    logic [C*W*S-1:0]   b_q, b_d;
    logic [H*W*S-1:0]   res_q, res_d;
    logic               done_q;

    logic               in_xfer;
    logic               out_xfer;
    logic               rise;
    logic               last_a;
    logic               last_b;
    logic               last_o;
    logic               tmo;
    logic [S-1:0]       out_sel;

    // One counter serves as load index, wait timer and drain index;
    // the states that use it are mutually exclusive.
    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;
    assign rise     = mm_done && !done_q;
    assign last_a   = (cnt_q == CW'(NA - 1));
    assign last_b   = (cnt_q == CW'(NB - 1));
    assign last_o   = (cnt_q == CW'(NO - 1));
    assign tmo      = (cnt_q == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_LOAD_A: begin
                if (in_xfer) begin
                    if (last_a) begin
                        state_d = ST_LOAD_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_LOAD_B: begin
                if (in_xfer) begin
                    if (last_b) begin
                        state_d = ST_FIRE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_FIRE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (rise) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else if (tmo) begin
                    state_d = ST_LOAD_A;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (out_xfer) begin
                    if (last_o) begin
                        state_d = ST_LOAD_A;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD_A;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        bus.in_ready  = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
        bus.out_valid = (state_q == ST_DRAIN);
        mm_start      = (state_q == ST_FIRE);
        busy          = (state_q == ST_FIRE) || (state_q == ST_WAIT) ||
                        (state_q == ST_DRAIN);
        err           = (state_q == ST_WAIT) && !rise && tmo;
    end

    // Operand writes, result capture
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        if (state_q == ST_LOAD_A && in_xfer) begin
            for (int k = 0; k < NA; k++) begin
                if (cnt_q == CW'(k)) begin
                    a_d[k*S +: S] = bus.in_data;
                end
            end
        end
        if (state_q == ST_LOAD_B && in_xfer) begin
            for (int k = 0; k < NB; k++) begin
                if (cnt_q == CW'(k)) begin
                    b_d[k*S +: S] = bus.in_data;
                end
            end
        end
        if (state_q == ST_WAIT && rise) begin
            res_d = mm_o;
        end
    end

    // Drained element select; zero outside DRAIN
    always_comb begin
        out_sel = '0;
        if (state_q == ST_DRAIN) begin
            for (int k = 0; k < NO; k++) begin
                if (cnt_q == CW'(k)) begin
                    out_sel = res_q[k*S +: S];
                end
            end
        end
    end

    assign bus.out_data = out_sel;
    assign mm_a         = a_q;
    assign mm_b         = b_q;

    // Datapath registers and the mm_done edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            done_q <= mm_done;
        end
    end

endmodule

// File: doc/matmul_driver.md
MATMUL_DRIVER -- requirements
Module: matmul_driver

Interface
REQ-001 Parameter S, default 32, element width in bits (IEEE-754 single).
REQ-002 Parameter H, default 2, rows of A and O.
REQ-003 Parameter C, default 2, columns of A and rows of B.
REQ-004 Parameter W, default 2, columns of B and O.
REQ-005 Parameter TIMEOUT, default 1024, maximum cycles to wait for mm_done.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 in_valid  input  1  operand element valid.
REQ-009 in_ready  output  1  driver accepts an operand element this cycle.
REQ-010 in_data  input  S  operand element.
REQ-011 out_valid  output  1  result element valid.
REQ-012 out_ready  input  1  consumer accepts the result element.
REQ-013 out_data  output  S  result element.
REQ-014 mm_start  output  1  one-cycle start pulse to the matmul engine.
REQ-015 mm_a  output  H*C*S  flattened A; element k occupies bits [k*S +: S].
REQ-016 mm_b  output  C*W*S  flattened B, same packing.
REQ-017 mm_o  input  H*W*S  flattened product from the engine, same packing.
REQ-018 mm_done  input  1  engine completion, level.
REQ-019 busy  output  1  high in FIRE, WAIT and DRAIN.
REQ-020 err  output  1  one-cycle pulse on timeout.

Function
REQ-021 FSM states: LOAD_A, LOAD_B, FIRE, WAIT, DRAIN.
REQ-022 Transfer rules: an in-transfer occurs when in_valid && in_ready; an out-transfer occurs when out_valid && out_ready.
REQ-023 LOAD_A: in_ready=1; each in-transfer writes element index k (row-major, k = r*C + c, k starting at 0) into mm_a.
REQ-024 LOAD_A: after element H*C-1 is written, the FSM moves to LOAD_B and the index counter clears to 0.
REQ-025 LOAD_B: in_ready=1; each in-transfer writes element k (k = r*W + c) into mm_b.
REQ-026 LOAD_B: after element C*W-1 is written, the FSM moves to FIRE.
REQ-027 in_ready=0 in FIRE, WAIT and DRAIN; in_valid is ignored in those states.
REQ-028 FIRE: mm_start=1 for exactly one cycle, then WAIT.
REQ-029 mm_a and mm_b hold stable from FIRE until the next LOAD_A write.
REQ-030 Completion detection: a registered copy of mm_done detects its rising edge (high now, low previous cycle); a level left high from a prior operation does not complete WAIT.
REQ-031 WAIT: on a rising edge of mm_done, mm_o is captured into the result register, the FSM enters DRAIN, and out_valid=1 from the next cycle.
REQ-032 WAIT: a cycle counter starts at 0 on entry; if it reaches TIMEOUT-1 with no rising edge, err pulses for one cycle and the FSM returns to LOAD_A with no output.
REQ-033 Rising edges of mm_done outside WAIT are ignored.
REQ-034 DRAIN: out_data = result element j, j from 0 to H*W-1; j advances only on an out-transfer.
REQ-035 DRAIN: out_data and out_valid stay stable while out_ready=0.
REQ-036 DRAIN: after the out-transfer of element H*W-1, out_valid drops and the FSM enters LOAD_A the next cycle with in_ready=1.
REQ-037 Index and element counters are sized ceil(log2(max(H*C, C*W, H*W, TIMEOUT)+1)) bits; there is no wrap within one operation.
REQ-038 No arithmetic is performed on data; elements pass bit-exact.

Reset
REQ-039 While rst_n=0, state=LOAD_A and all counters, mm_a, mm_b, the result register and the mm_done edge register are 0.
REQ-040 While rst_n=0, in_ready=1 and out_valid=0, mm_start=0, err=0, busy=0, out_data=0.
REQ-041 Reset asserted in any state, mid-load or mid-drain, aborts immediately and discards partial data; no mm_start or out_valid follows.

Verification
REQ-042 Default parameters; stream 8 elements of 0x40a00000 with in_valid held high -> mm_start pulses one cycle after the 8th transfer; mm_a = mm_b = 4x 0x40a00000.
REQ-043 Engine stub raises mm_done 5 cycles after mm_start with mm_o = 4x 0x42480000 (50.0) -> out_valid rises the cycle after the edge; four out_data = 0x42480000 with out_ready=1, then in_ready=1.
REQ-044 Same as REQ-043 but out_ready toggles 1,0,0,1,... -> exactly 4 transfers; out_data is unchanged on stalled cycles; elements 0..3 appear in packing order when distinct values are used.
REQ-045 mm_done held high before and after start, with no new rising edge -> err pulses once TIMEOUT cycles after WAIT entry; FSM returns to LOAD_A; out_valid never asserts.
REQ-046 rst_n pulled low after 3 A-elements, then released, then 8 new elements loaded -> mm_a holds only the new values; exactly one mm_start pulse.
REQ-047 in_valid gapped (1,0,1,0) during LOAD -> element order is preserved; mm_start fires only after 8 transfers.
